// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-memory load arbiter: FSM state
// encodings, instruction width and the byte stride between consecutive words.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } arb_state_e;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned BYTE_STRIDE = 4;

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Loader handshake plus instruction-memory bus. The arbiter uses the slave
// modport; whoever drives the loader and observes the memory uses master.
interface imem_load_arbiter_if;
  import fetch_pkg::*;

  logic               ld_start;
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;

  logic               imem_read;
  logic               imem_write;
  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    output ld_ready, imem_read, imem_write, imem_addr, imem_wdata
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    input  ld_ready, imem_read, imem_write, imem_addr, imem_wdata
  );

endinterface

// File: rtl/load_addr_counter.sv
// Word counter for one load session. Saturates at DEPTH so an over-long image
// never wraps back onto already-written words; the byte address is derived
// from the count so the two can never disagree.
module load_addr_counter
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_beat,
  output logic [CW-1:0] o_count,
  output logic [31:0]   o_addr,
  output logic          o_full
);

  logic [CW-1:0] r_count;
  logic          w_full;

  assign w_full = (r_count == CW'(DEPTH));

  // Count accepted beats; clear wins over a beat in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_beat && !w_full) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_addr  = BASE_ADDR + (32'(r_count) * 32'(BYTE_STRIDE));

endmodule

// File: rtl/imem_load_arbiter.sv
// Owns the instruction-memory port: boots the core by streaming a program
// image in while the core is held, then hands the port to fetch. A start
// during RUN pauses fetch for one cycle, then reloads from BASE_ADDR.
//
//   state | meaning
//   HOLD  | core held in reset, port idle, waiting for start (or pending)
//   LOAD  | loader beats written at consecutive word addresses
//   DRAIN | one idle cycle so the last write lands before the first read
//   RUN   | core released, fetch owns the port
//   PAUSE | fetch stalled, in-flight fetch retires, reload pending
module imem_load_arbiter
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  imem_load_arbiter_if.slave  bus,
  input  logic [31:0]         i_fetch_addr,
  output logic                o_fetch_stall,
  output logic                o_core_run,
  output logic [CW-1:0]       o_ld_count,
  output logic                o_ld_overflow
);

  arb_state_e    r_state;
  logic          r_pending;
  logic          r_core_run;
  logic          r_fetch_stall;
  logic          r_overflow;

  logic          w_in_load;
  logic          w_beat;
  logic          w_clear;
  logic          w_full;
  logic [31:0]   w_ld_addr;
  logic [CW-1:0] w_count;

  assign w_in_load = (r_state == ST_LOAD);
  assign w_beat    = w_in_load && bus.ld_valid;
  // The counter clears on the same edge that moves HOLD into LOAD.
  assign w_clear   = (r_state == ST_HOLD) && (bus.ld_start || r_pending);

  load_addr_counter #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_clear),
    .i_beat    (w_beat),
    .o_count   (w_count),
    .o_addr    (w_ld_addr),
    .o_full    (w_full)
  );

  // Sequencer; core_run/fetch_stall are registered alongside the state so
  // they toggle only on clock edges.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_HOLD;
      r_pending     <= 1'b0;
      r_core_run    <= 1'b0;
      r_fetch_stall <= 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_core_run    <= 1'b0;
          r_fetch_stall <= 1'b1;
          if (bus.ld_start || r_pending) begin
            r_state   <= ST_LOAD;
            r_pending <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_core_run    <= 1'b0;
          r_fetch_stall <= 1'b1;
          if (w_beat && bus.ld_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state       <= ST_RUN;
          r_core_run    <= 1'b1;
          r_fetch_stall <= 1'b0;
        end
        ST_RUN: begin
          r_core_run <= 1'b1;
          if (bus.ld_start) begin
            r_state       <= ST_PAUSE;
            r_fetch_stall <= 1'b1;
          end else begin
            r_fetch_stall <= 1'b0;
          end
        end
        ST_PAUSE: begin
          r_state       <= ST_HOLD;
          r_pending     <= 1'b1;
          r_core_run    <= 1'b0;
          r_fetch_stall <= 1'b1;
        end
        default: begin
          r_state       <= ST_HOLD;
          r_pending     <= 1'b0;
          r_core_run    <= 1'b0;
          r_fetch_stall <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a beat offered once the image already fills the memory.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_beat && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.ld_ready   = w_in_load;
  assign bus.imem_write = w_beat && !w_full;
  assign bus.imem_read  = (r_state == ST_RUN);
  assign bus.imem_wdata = w_in_load ? bus.ld_data : '0;

  // Port address mux; parked at BASE_ADDR whenever nobody owns the port.
  always_comb begin
    bus.imem_addr = BASE_ADDR;
    if (r_state == ST_RUN) begin
      bus.imem_addr = i_fetch_addr;
    end else if (w_in_load) begin
      bus.imem_addr = w_ld_addr;
    end
  end

  assign o_core_run    = r_core_run;
  assign o_fetch_stall = r_fetch_stall;
  assign o_ld_count    = w_count;
  assign o_ld_overflow = r_overflow;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter with a 4-word memory so overflow is reachable.
// A phase-level model predicts every output each cycle; directed sections pin
// latencies, addresses and data with literal expectations.
module tb_imem_load_arbiter;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CW   = $clog2(D) + 1;

  localparam int MP_HOLD = 0, MP_LOAD = 1, MP_DRAIN = 2, MP_RUN = 3, MP_PAUSE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_stall, core_run, ld_overflow;
  logic [CW-1:0] ld_count;

  imem_load_arbiter_if bus();

  imem_load_arbiter #(.DEPTH(D), .BASE_ADDR(BASE)) u_dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .bus           (bus.slave),
    .i_fetch_addr  (fetch_addr),
    .o_fetch_stall (fetch_stall),
    .o_core_run    (core_run),
    .o_ld_count    (ld_count),
    .o_ld_overflow (ld_overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase the arbiter is in, words written, overflow, pending.
  int m_phase = MP_HOLD;
  int m_cnt   = 0;
  bit m_ovf   = 0;
  bit m_pend  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = MP_HOLD; m_cnt = 0; m_ovf = 0; m_pend = 0;
    end else begin
      case (m_phase)
        MP_HOLD:  if (bus.ld_start || m_pend) begin m_phase = MP_LOAD; m_cnt = 0; m_pend = 0; end
        MP_LOAD: begin
          if (bus.ld_valid) begin
            if (m_cnt < D) m_cnt++;
            else m_ovf = 1;
            if (bus.ld_last) m_phase = MP_DRAIN;
          end
        end
        MP_DRAIN: m_phase = MP_RUN;
        MP_RUN:   if (bus.ld_start) m_phase = MP_PAUSE;
        default:  begin m_phase = MP_HOLD; m_pend = 1; end
      endcase
    end
  end

  logic [31:0] waddr[$];
  logic [31:0] wdat[$];

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit          ld   = (m_phase == MP_LOAD);
      automatic bit          beat = ld && bus.ld_valid;
      automatic logic [31:0] ea   = (m_phase == MP_RUN) ? fetch_addr :
                                    ld ? BASE + 32'(4 * m_cnt) : BASE;
      chk("core_run",  32'(core_run),        32'(m_phase == MP_RUN || m_phase == MP_PAUSE));
      chk("stall",     32'(fetch_stall),     32'(m_phase != MP_RUN));
      chk("ld_ready",  32'(bus.ld_ready),    32'(ld));
      chk("imem_read", 32'(bus.imem_read),   32'(m_phase == MP_RUN));
      chk("imem_write",32'(bus.imem_write),  32'(beat && m_cnt < D));
      chk("imem_addr", bus.imem_addr,        ea);
      chk("imem_wdata",bus.imem_wdata,       ld ? bus.ld_data : 32'h0);
      chk("ld_count",  32'(ld_count),        32'(m_cnt));
      chk("overflow",  32'(ld_overflow),     32'(m_ovf));
      chk("rd_wr_excl",32'(bus.imem_read && bus.imem_write), 32'h0);
      chk("rd_owner",  32'(bus.imem_read && !(core_run && !fetch_stall)), 32'h0);
      if (bus.imem_write) begin
        waddr.push_back(bus.imem_addr);
        wdat.push_back(bus.imem_wdata);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l);
    bus.ld_valid = v; bus.ld_data = d; bus.ld_last = l;
    tick();
    bus.ld_valid = 0; bus.ld_last = 0;
  endtask

  task automatic pulse_start;
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
  endtask

  initial begin
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
    #12;
    chk("rst_core_run", 32'(core_run), 32'h0);
    chk("rst_stall",    32'(fetch_stall), 32'h1);
    chk("rst_addr",     bus.imem_addr, BASE);
    rst_n = 1;
    tick();

    // Boot load of four words.
    pulse_start();
    chk("boot_ready", 32'(bus.ld_ready), 32'h1);
    for (int i = 0; i < 4; i++) beat(1, 32'h2001_0005 + 32'(i), i == 3);
    chk("boot_count", 32'(ld_count), 32'd4);
    chk("boot_run_n1", 32'(core_run), 32'h0);
    tick();
    chk("boot_run_n2", 32'(core_run), 32'h1);
    chk("boot_read_n2", 32'(bus.imem_read), 32'h1);
    chk("boot_nwr", 32'(waddr.size()), 32'd4);
    for (int i = 0; i < 4 && i < waddr.size(); i++) begin
      chk("boot_waddr", waddr[i], 32'(4 * i));
      chk("boot_wdata", wdat[i], 32'h2001_0005 + 32'(i));
    end

    // Mid-run reload, then a gapped session.
    fetch_addr = 32'h10;
    #1;
    chk("run_addr", bus.imem_addr, 32'h10);
    waddr.delete(); wdat.delete();
    pulse_start();
    chk("rl_stall_p1", 32'(fetch_stall), 32'h1);
    chk("rl_run_p1",   32'(core_run), 32'h1);
    chk("rl_read_p1",  32'(bus.imem_read), 32'h0);
    tick();
    chk("rl_run_p2",   32'(core_run), 32'h0);
    tick();
    chk("rl_ready_p3", 32'(bus.ld_ready), 32'h1);
    chk("rl_count_p3", 32'(ld_count), 32'h0);
    beat(1, 32'hA0, 0); beat(0, 32'hA1, 0); beat(1, 32'hA2, 0);
    beat(0, 32'hA3, 0); beat(1, 32'hA4, 1);
    chk("gap_nwr", 32'(waddr.size()), 32'd3);
    for (int i = 0; i < 3 && i < waddr.size(); i++) chk("gap_waddr", waddr[i], 32'(4 * i));
    if (wdat.size() == 3) chk("gap_wdata2", wdat[2], 32'hA4);
    tick();

    // Overflow: six beats into a four-word memory.
    waddr.delete(); wdat.delete();
    pulse_start(); tick(); tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        bus.ld_valid = 1; #1;
        chk("ovf_wr_b5", 32'(bus.imem_write), 32'h0);
        chk("ovf_rdy_b5", 32'(bus.ld_ready), 32'h1);
      end
      beat(1, 32'hC0 + 32'(i), i == 5);
    end
    chk("ovf_nwr", 32'(waddr.size()), 32'd4);
    chk("ovf_flag", 32'(ld_overflow), 32'h1);
    chk("ovf_count", 32'(ld_count), 32'd4);
    tick();
    chk("ovf_persist", 32'(ld_overflow & core_run), 32'h1);

    // Async reset mid-LOAD.
    pulse_start(); tick(); tick();
    beat(1, 32'hD0, 0);
    bus.ld_valid = 1; bus.ld_data = 32'hD1;
    #2 rst_n = 0;
    #1;
    chk("ar_core_run", 32'(core_run), 32'h0);
    chk("ar_stall",    32'(fetch_stall), 32'h1);
    chk("ar_ready",    32'(bus.ld_ready), 32'h0);
    chk("ar_write",    32'(bus.imem_write), 32'h0);
    chk("ar_addr",     bus.imem_addr, BASE);
    chk("ar_wdata",    bus.imem_wdata, 32'h0);
    chk("ar_count",    32'(ld_count), 32'h0);
    chk("ar_ovf",      32'(ld_overflow), 32'h0);
    bus.ld_valid = 0;
    @(negedge clk); #2 rst_n = 1;
    tick();
    waddr.delete(); wdat.delete();
    pulse_start();
    beat(1, 32'hE0, 1);
    chk("ar_nwr", 32'(waddr.size()), 32'd1);
    if (waddr.size() > 0) chk("ar_waddr0", waddr[0], BASE);
    tick(); tick();

    // Random traffic; the model and per-cycle checks do the work.
    for (int c = 0; c < 10000; c++) begin
      bus.ld_start = ($urandom_range(0, 19) == 0);
      bus.ld_valid = $urandom_range(0, 1);
      bus.ld_last  = ($urandom_range(0, 7) == 0);
      bus.ld_data  = $urandom;
      fetch_addr   = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_last = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
